modulo_buffer_entrada_contador: RTL and testbench
=================================================

Name: modulo_buffer_entrada_contador

Overview:
Upstream feeder for the counter-control state machine. It queues operator-entered count values in a small circular FIFO and presents the oldest value in a holding register. It drives the controller's register-loaded flag (load_reg) and buffer-empty flag (empty_buffer). It accepts the controller's clear_reg strobe to consume the held value and refill the register from the FIFO.

Parameters:
WIDTH, 8, bit width of each queued count value
DEPTH, 4, FIFO entries behind the holding register (power of two, >=2)
CNT_W, $clog2(DEPTH)+1, width of the occupancy output

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
enable  input  1  when 0, every register holds its value
push  input  1  level from the debounced enter key; acts on its rising edge only
data_in  input  WIDTH  value captured on an accepted push
clear_reg  input  1  from the controller: consume the held value
reg_value  output  WIDTH  holding-register contents, fed to the counter load input
load_reg  output  1  holding register contains a valid value
empty_buffer  output  1  FIFO behind the register is empty (count==0)
full  output  1  count==DEPTH
overflow  output  1  one-cycle pulse when a push is dropped
count  output  CNT_W  FIFO occupancy, excludes the holding register

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=rd_ptr=0, count=0, reg_value=0, load_reg=0, overflow=0, push_d=0. This gives empty_buffer=1 and full=0. Reset mid-operation discards all queued and held values immediately.
- enable=0: all registers are frozen, including push_d and overflow. A push held high across enable=0 is therefore detected once enable returns to 1.
- Edge detect: push_d is registered; push_edge = push & ~push_d. Exactly one write attempt per rising edge of push.
- Refill condition: refill = (~load_reg | clear_reg) & (count!=0).
- Write condition: write = push_edge & (count<DEPTH | refill).
  - If push_edge=1 and write=0, the push is dropped, storage is unchanged, and overflow=1 for the following cycle only.
- On refill: reg_value <= mem[rd_ptr], rd_ptr+1, load_reg <= 1.
- clear_reg with count==0: load_reg <= 0, reg_value <= 0.
- clear_reg while load_reg=0: harmless. Refill proceeds as normal if count!=0.
- On write: mem[wr_ptr] <= data_in, wr_ptr+1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count update: +1 on write only, -1 on refill only, unchanged when both or neither occur.
- Latency: push edge sampled at edge k, value enters FIFO (count updates). At edge k+1 it refills an empty register, so load_reg is high after k+1. No FIFO bypass.
- Same-cycle clear_reg and refill: the register goes directly to the next value with no load_reg gap.
- Full with simultaneous refill: the write is accepted, count stays DEPTH, and no overflow is flagged.
- Outputs empty_buffer, full and load_reg are pure functions of registered state, so they are glitch-free for the controller.

Decomposition:
- Shared package constants: BUF_WIDTH=8, BUF_DEPTH=4, and the derived pointer and count widths, so the counter datapath uses the same WIDTH.
- Natural sub-module: modulo_fifo_circular, containing storage, pointers, count, full and empty.
- The top adds the edge detector, the holding register, the refill/write logic and the overflow pulse.

Test Plan:
1. Reset, then single push data_in=8'h05: count=1 after edge k. After edge k+1: load_reg=1, reg_value=05, count=0, empty_buffer=1.
2. Push 01,02,03,04,05 with no clear_reg: register holds 01, count=4, full=1. A 6th push 06 gives overflow=1 for one cycle and count stays 4.
3. From scenario 2, pulse clear_reg once: in the same edge reg_value=02, load_reg stays 1, count=3. Repeat four more times: last clear gives load_reg=0, reg_value=0.
4. Full FIFO, push edge and clear_reg in the same cycle: write accepted, count stays 4, no overflow. Values later drain in order, with pointer wrap verified.
5. Hold push high for 10 cycles: exactly one entry is written. Drop enable while push rises: no write. Raise enable: one write.
6. Assert rst low between clock edges with 3 entries held: all outputs reach reset values immediately. Release reset: push 0A gives reg_value=0A after 2 edges.

Source files
------------

// File: rtl/modulo_buffer_entrada_contador_pkg.sv
// modulo_buffer_entrada_contador_pkg: shared sizing for the input buffer and the counter datapath
package modulo_buffer_entrada_contador_pkg;
    localparam int BUF_WIDTH = 8;
    localparam int BUF_DEPTH = 4;
    localparam int BUF_PTR_W = $clog2(BUF_DEPTH);
    localparam int BUF_CNT_W = BUF_PTR_W + 1;
endpackage

// File: rtl/modulo_fifo_circular.sv
// modulo_fifo_circular: circular FIFO with occupancy count, full and empty flags
module modulo_fifo_circular #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    // Occupancy moves only when exactly one of write/read happens
    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en) count_d = count_q + 1'b1;
        else if (rd_en && !wr_en) count_d = count_q - 1'b1;
    end

    // Storage needs no reset: only entries between the pointers are ever read
    always_ff @(posedge clk)
        if (wr_en) mem_q[wr_ptr_q] <= wdata;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = count_q == CNT_W'(DEPTH);
    assign empty = count_q == '0;
endmodule

// File: rtl/modulo_buffer_entrada_contador.sv
// modulo_buffer_entrada_contador: queues entered count values and presents the oldest in a holding register
module modulo_buffer_entrada_contador
    import modulo_buffer_entrada_contador_pkg::*;
#(
    parameter int WIDTH = BUF_WIDTH,
    parameter int DEPTH = BUF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clear_reg,
    output logic [WIDTH-1:0] reg_value,
    output logic             load_reg,
    output logic             empty_buffer,
    output logic             full,
    output logic             overflow,
    output logic [CNT_W-1:0] count
);
    logic             push_d_q, push_d_d;
    logic             overflow_q, overflow_d;
    logic             load_reg_q, load_reg_d;
    logic [WIDTH-1:0] reg_value_q, reg_value_d;
    logic             push_edge, refill, write;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_full, fifo_empty;

    modulo_fifo_circular #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (write & enable),
        .rd_en (refill & enable),
        .wdata (data_in),
        .rdata (fifo_rdata),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Refill takes priority over clear so a consumed value is replaced without a load_reg gap
    always_comb begin
        push_edge   = push & ~push_d_q;
        refill      = (~load_reg_q | clear_reg) & ~fifo_empty;
        write       = push_edge & (~fifo_full | refill);
        push_d_d    = push;
        overflow_d  = push_edge & ~write;
        reg_value_d = refill ? fifo_rdata : clear_reg ? '0 : reg_value_q;
        load_reg_d  = refill | (load_reg_q & ~clear_reg);
    end

    // Whole block freezes while enable is low, including the edge detector
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            push_d_q    <= 1'b0;
            overflow_q  <= 1'b0;
            load_reg_q  <= 1'b0;
            reg_value_q <= '0;
        end else if (enable) begin
            push_d_q    <= push_d_d;
            overflow_q  <= overflow_d;
            load_reg_q  <= load_reg_d;
            reg_value_q <= reg_value_d;
        end

    assign reg_value    = reg_value_q;
    assign load_reg     = load_reg_q;
    assign overflow     = overflow_q;
    assign full         = fifo_full;
    assign empty_buffer = fifo_empty;
endmodule

// File: tb/tb_modulo_buffer_entrada_contador.sv
// tb_modulo_buffer_entrada_contador: table vectors, corner sequences and random run against a queue model
module tb_modulo_buffer_entrada_contador;
    localparam int W = 8;
    localparam int D = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          push = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          clear_reg = 1'b0;
    logic [W-1:0]  reg_value;
    logic          load_reg, empty_buffer, full, overflow;
    logic [CW-1:0] count;

    int n_chk = 0;
    int n_fail = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] m_reg;
    logic         m_valid, m_ov, m_pushd;

    typedef struct {
        logic         en, p, c;
        logic [W-1:0] din;
        logic [W-1:0] e_reg;
        logic         e_load;
        int           e_cnt;
        logic         e_ov;
    } vec_t;
    vec_t tbl[$];

    modulo_buffer_entrada_contador dut (
        .clk(clk), .rst(rst), .enable(enable), .push(push), .data_in(data_in),
        .clear_reg(clear_reg), .reg_value(reg_value), .load_reg(load_reg),
        .empty_buffer(empty_buffer), .full(full), .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_reg = '0;
        m_valid = 1'b0;
        m_ov = 1'b0;
        m_pushd = 1'b0;
    endtask

    // Behaviour from the rules: oldest value moves to the register, new values join the tail
    task automatic model_edge();
        bit pe, rf, wr;
        if (!enable) return;
        pe = push && !m_pushd;
        rf = (!m_valid || clear_reg) && q.size() != 0;
        wr = pe && (q.size() < D || rf);
        if (rf) begin
            m_reg = q.pop_front();
            m_valid = 1'b1;
        end else if (clear_reg) begin
            m_reg = '0;
            m_valid = 1'b0;
        end
        if (wr) q.push_back(data_in);
        m_ov = pe && !wr;
        m_pushd = push;
    endtask

    task automatic chk_model();
        chk("m_reg", 32'(reg_value), 32'(m_reg));
        chk("m_load", 32'(load_reg), 32'(m_valid));
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_empty", 32'(empty_buffer), 32'(q.size() == 0));
        chk("m_full", 32'(full), 32'(q.size() == D));
        chk("m_ovf", 32'(overflow), 32'(m_ov));
    endtask

    task automatic cycle(logic en, logic p, logic c, logic [W-1:0] din);
        enable = en;
        push = p;
        clear_reg = c;
        data_in = din;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        logic [W-1:0] drain [4];
        drain = '{8'h12, 8'h13, 8'h14, 8'h15};
        model_reset();
        tbl.push_back('{1, 1, 0, 8'h05, 8'h00, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 8'h00, 8'h05, 1, 0, 0});
        tbl.push_back('{1, 0, 1, 8'h00, 8'h00, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 8'h01, 8'h00, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 8'h00, 8'h01, 1, 0, 0});
        tbl.push_back('{1, 1, 0, 8'h02, 8'h01, 1, 1, 0});
        tbl.push_back('{1, 0, 0, 8'h00, 8'h01, 1, 1, 0});
        tbl.push_back('{1, 1, 0, 8'h03, 8'h01, 1, 2, 0});
        tbl.push_back('{1, 0, 0, 8'h00, 8'h01, 1, 2, 0});
        tbl.push_back('{1, 1, 0, 8'h04, 8'h01, 1, 3, 0});
        tbl.push_back('{1, 0, 0, 8'h00, 8'h01, 1, 3, 0});
        tbl.push_back('{1, 1, 0, 8'h05, 8'h01, 1, 4, 0});
        tbl.push_back('{1, 0, 0, 8'h00, 8'h01, 1, 4, 0});
        tbl.push_back('{1, 1, 0, 8'h06, 8'h01, 1, 4, 1});
        tbl.push_back('{1, 0, 0, 8'h00, 8'h01, 1, 4, 0});
        tbl.push_back('{1, 0, 1, 8'h00, 8'h02, 1, 3, 0});
        tbl.push_back('{1, 0, 1, 8'h00, 8'h03, 1, 2, 0});
        tbl.push_back('{1, 0, 1, 8'h00, 8'h04, 1, 1, 0});
        tbl.push_back('{1, 0, 1, 8'h00, 8'h05, 1, 0, 0});
        tbl.push_back('{1, 0, 1, 8'h00, 8'h00, 0, 0, 0});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_reg", 32'(reg_value), 0);
        chk("rst_load", 32'(load_reg), 0);
        chk("rst_empty", 32'(empty_buffer), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_count", 32'(count), 0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].en, tbl[i].p, tbl[i].c, tbl[i].din);
            chk($sformatf("tbl%0d_reg", i), 32'(reg_value), 32'(tbl[i].e_reg));
            chk($sformatf("tbl%0d_load", i), 32'(load_reg), 32'(tbl[i].e_load));
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].e_cnt == D));
            chk($sformatf("tbl%0d_empty", i), 32'(empty_buffer), 32'(tbl[i].e_cnt == 0));
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].e_ov));
        end

        for (int v = 0; v < 5; v++) begin
            cycle(1, 1, 0, 8'h10 + 8'(v));
            chk_model();
            cycle(1, 0, 0, 8'h00);
            chk_model();
        end
        chk("s4_full", 32'(full), 1);
        chk("s4_reg0", 32'(reg_value), 32'h10);
        cycle(1, 1, 1, 8'h15);
        chk("s4_count", 32'(count), 4);
        chk("s4_ovf", 32'(overflow), 0);
        chk("s4_reg", 32'(reg_value), 32'h11);
        cycle(1, 0, 0, 8'h00);
        chk("s4_ovf2", 32'(overflow), 0);
        for (int k = 0; k < 4; k++) begin
            cycle(1, 0, 1, 8'h00);
            chk($sformatf("s4_drain%0d", k), 32'(reg_value), 32'(drain[k]));
            chk($sformatf("s4_dload%0d", k), 32'(load_reg), 1);
        end
        cycle(1, 0, 1, 8'h00);
        chk("s4_end_load", 32'(load_reg), 0);
        chk_model();

        for (int k = 0; k < 10; k++) begin
            cycle(1, 1, 0, 8'h2C);
            chk_model();
        end
        chk("s5_reg", 32'(reg_value), 32'h2C);
        chk("s5_count", 32'(count), 0);
        cycle(1, 0, 0, 8'h00);
        for (int k = 0; k < 3; k++) cycle(0, 1, 0, 8'h33);
        chk("s5_frz_count", 32'(count), 0);
        chk("s5_frz_reg", 32'(reg_value), 32'h2C);
        cycle(1, 1, 0, 8'h33);
        chk("s5_en_count", 32'(count), 1);
        cycle(1, 1, 0, 8'h44);
        chk("s5_hold_count", 32'(count), 1);
        chk_model();
        cycle(1, 0, 0, 8'h00);

        cycle(1, 1, 0, 8'h50);
        cycle(1, 0, 0, 8'h00);
        cycle(1, 1, 0, 8'h51);
        chk("s6_pre_count", 32'(count), 3);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("s6_reg", 32'(reg_value), 0);
        chk("s6_load", 32'(load_reg), 0);
        chk("s6_empty", 32'(empty_buffer), 1);
        chk("s6_full", 32'(full), 0);
        chk("s6_ovf", 32'(overflow), 0);
        chk("s6_count", 32'(count), 0);
        #1 rst = 1'b1;
        cycle(1, 1, 0, 8'h0A);
        chk("s6_p_count", 32'(count), 1);
        cycle(1, 0, 0, 8'h00);
        chk("s6_p_reg", 32'(reg_value), 32'h0A);
        chk("s6_p_load", 32'(load_reg), 1);

        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0, 8'($urandom));
            chk_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
